// File: rtl/pattern_count_engine_pkg.sv
// Shared types and constants for the pattern-count engine.
package pce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RDPAT,
        SCAN,
        WR0,
        WR1,
        WR2,
        DONE
    } state_t;

    localparam int RES_OFF_CTB = 0;
    localparam int RES_OFF_CTO = 1;
    localparam int RES_OFF_CTS = 2;

endpackage

// File: rtl/pattern_count_engine_window_matcher.sv
// Combinational window matcher: counts pattern hits in one message byte, both
// strictly inside the byte and across the boundary with the previous byte's tail.
module window_matcher #(
    parameter int PAT_W = 5
) (
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-2:0] carry,
    input  logic [7:0]       data_byte,
    input  logic             first_byte,
    output logic [3:0]       in_count,
    output logic             any_match,
    output logic [3:0]       cross_count
);

    logic [PAT_W+6:0] joined;

    assign joined = {carry, data_byte};

    // Window j ends at byte bit j; low windows (j <= 8-PAT_W) lie fully inside the byte.
    // The first byte has no real predecessor, so its carry-spanning windows are skipped.
    always_comb begin
        in_count    = 4'd0;
        cross_count = 4'd0;
        for (int j = 0; j < 8; j++) begin
            if (joined[j +: PAT_W] == pattern) begin
                if (j <= 8 - PAT_W) begin
                    in_count = in_count + 4'd1;
                end
                if (!first_byte || (j <= 8 - PAT_W)) begin
                    cross_count = cross_count + 4'd1;
                end
            end
        end
        any_match = (in_count != 4'd0);
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Pattern-count accelerator: reads a pattern byte and NBYTES message bytes, then
// writes in-byte, byte and crossing match counts back to data memory.
module pattern_count_engine
    import pce_pkg::*;
#(
    parameter int PAT_W    = 5,
    parameter int NBYTES   = 32,
    parameter int ADDR_W   = 8,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int SUM_W = CNT_W + 5;
    localparam int BYTE_W = CNT_W + 8;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(NBYTES);
    localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] FIRST_K = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PAT_A   = ADDR_W'(PAT_ADDR);
    localparam logic [ADDR_W-1:0] RES_CTB = ADDR_W'(RES_ADDR + RES_OFF_CTB);
    localparam logic [ADDR_W-1:0] RES_CTO = ADDR_W'(RES_ADDR + RES_OFF_CTO);
    localparam logic [ADDR_W-1:0] RES_CTS = ADDR_W'(RES_ADDR + RES_OFF_CTS);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [3:0]       inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        return (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // Wide counters are clipped to 255 rather than wrapped when written as a byte.
    function automatic logic [7:0] to_byte(input logic [CNT_W-1:0] cnt);
        logic [BYTE_W-1:0] wide;
        wide = BYTE_W'(cnt);
        return (wide > BYTE_W'(255)) ? 8'hFF : wide[7:0];
    endfunction

    state_t state, state_nx;

    logic [ADDR_W-1:0] scan_k, scan_k_nx;
    logic [ADDR_W-1:0] rd_addr_nx;
    logic [PAT_W-1:0]  pattern_q, pattern_nx;
    logic [PAT_W-2:0]  carry_q, carry_nx;
    logic [CNT_W-1:0]  ctb, ctb_nx;
    logic [CNT_W-1:0]  cto, cto_nx;
    logic [CNT_W-1:0]  cts, cts_nx;
    logic              wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [7:0]        wr_data_nx;

    logic [3:0] in_cnt;
    logic [3:0] cross_cnt;
    logic       any_hit;

    window_matcher #(
        .PAT_W(PAT_W)
    ) u_matcher (
        .pattern    (pattern_q),
        .carry      (carry_q),
        .data_byte  (rd_data),
        .first_byte (scan_k == FIRST_K),
        .in_count   (in_cnt),
        .any_match  (any_hit),
        .cross_count(cross_cnt)
    );

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // SCAN cycle k fetches byte k while the byte fetched in cycle k-1 is scored;
    // cycle 0 instead captures the pattern requested during RDPAT.
    always_comb begin
        state_nx   = state;
        scan_k_nx  = scan_k;
        rd_addr_nx = rd_addr;
        pattern_nx = pattern_q;
        carry_nx   = carry_q;
        ctb_nx     = ctb;
        cto_nx     = cto;
        cts_nx     = cts;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx   = RDPAT;
                    rd_addr_nx = PAT_A;
                    scan_k_nx  = '0;
                    carry_nx   = '0;
                    ctb_nx     = '0;
                    cto_nx     = '0;
                    cts_nx     = '0;
                end
            end
            RDPAT: begin
                state_nx   = SCAN;
                rd_addr_nx = '0;
                scan_k_nx  = '0;
            end
            SCAN: begin
                if (scan_k == '0) begin
                    pattern_nx = rd_data[7 -: PAT_W];
                end else begin
                    carry_nx = rd_data[PAT_W-2:0];
                    ctb_nx   = sat_add(ctb, in_cnt);
                    cto_nx   = any_hit ? sat_add(cto, 4'd1) : cto;
                    cts_nx   = sat_add(cts, cross_cnt);
                end
                if (scan_k < LAST_RD) begin
                    rd_addr_nx = scan_k + FIRST_K;
                end
                if (scan_k == LAST_K) begin
                    state_nx   = WR0;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = RES_CTB;
                    wr_data_nx = to_byte(ctb_nx);
                end else begin
                    scan_k_nx = scan_k + FIRST_K;
                end
            end
            WR0: begin
                state_nx   = WR1;
                wr_en_nx   = 1'b1;
                wr_addr_nx = RES_CTO;
                wr_data_nx = to_byte(cto);
            end
            WR1: begin
                state_nx   = WR2;
                wr_en_nx   = 1'b1;
                wr_addr_nx = RES_CTS;
                wr_data_nx = to_byte(cts);
            end
            WR2: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_k    <= '0;
            rd_addr   <= '0;
            pattern_q <= '0;
            carry_q   <= '0;
            ctb       <= '0;
            cto       <= '0;
            cts       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            scan_k    <= scan_k_nx;
            rd_addr   <= rd_addr_nx;
            pattern_q <= pattern_nx;
            carry_q   <= carry_nx;
            ctb       <= ctb_nx;
            cto       <= cto_nx;
            cts       <= cts_nx;
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
        end
    end

endmodule
